// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus between the MEM stage,
// the load/store unit and the data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_wd, dm_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_addr, dm_wd, dm_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-index translation, sub-word extension,
// read-modify-write for byte/half stores and alignment/range error checking.
module load_store_unit #(
  parameter int DM_WORDS = 32
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic        we_out_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_size == 2'b11) req_err = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0]) req_err = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, bus.req_addr[31:2]} >= 32'(DM_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    lane_byte = bus.dm_rd[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_data = unsigned_q ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_data = bus.dm_rd;
    endcase
  end

  // The merge word is the current memory word with only the addressed lane(s) replaced.
  always_comb begin
    merged = bus.dm_rd;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      addr_q       <= 32'h0;
      wd_q         <= 32'h0;
      we_out_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q       <= bus.req_we;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            lane_q     <= bus.req_addr[1:0];
            wdata_q    <= bus.req_wdata[15:0];
            if (req_err) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state    <= ACCESS;
              addr_q   <= {2'b00, bus.req_addr[31:2]};
              we_out_q <= bus.req_we && bus.req_size == 2'b10;
              wd_q     <= (bus.req_we && bus.req_size == 2'b10) ? bus.req_wdata : 32'h0;
            end
          end
        end
        ACCESS: begin
          if (we_q && size_q != 2'b10) begin
            state    <= WRITE;
            wd_q     <= merged;
            we_out_q <= 1'b1;
          end else begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= we_q ? 32'h0 : load_data;
            addr_q       <= 32'h0;
            wd_q         <= 32'h0;
            we_out_q     <= 1'b0;
          end
        end
        WRITE: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          addr_q       <= 32'h0;
          wd_q         <= 32'h0;
          we_out_q     <= 1'b0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst keeps a write from committing at the same edge that resets the unit.
  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.dm_we      = we_out_q && !rst;
  assign bus.dm_addr    = addr_q;
  assign bus.dm_wd      = wd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// requests compared against a lane-arithmetic model of memory.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.DM_WORDS(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [32];
  logic [31:0] refMem [32];
  logic        pokeEn;
  logic [4:0]  pokeIdx;
  logic [31:0] pokeData;

  int cycle = 0;
  int acceptCycle = 0;
  int weCount = 0;
  int weOffset = 0;
  logic [31:0] weIdx = 32'h0;
  logic [31:0] weData = 32'h0;

  int checks = 0;
  int passes = 0;

  assign bus.dm_rd = mem[bus.dm_addr[4:0]];

  always @(posedge clk) begin
    if (bus.dm_we) mem[bus.dm_addr[4:0]] <= bus.dm_wd;
    else if (pokeEn) mem[pokeIdx] <= pokeData;
  end

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (bus.dm_we) begin
      weCount  <= weCount + 1;
      weOffset <= cycle - acceptCycle;
      weIdx    <= bus.dm_addr;
      weData   <= bus.dm_wd;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    pokeEn = 1'b1;
    pokeIdx = 5'(idx);
    pokeData = data;
    refMem[idx] = data;
    @(posedge clk);
    #1 pokeEn = 1'b0;
  endtask

  // Reference: byte-lane arithmetic on a plain word array.
  task automatic modelAccess(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] rdata,
                             output logic [31:0] newWord, output int latency);
    longint unsigned idx, nbits, mask, shift, oldWord, v;
    idx = longint'(addr) / 4;
    err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
          (size == 2'd2 && addr % 4 != 0) || idx >= 32;
    oldWord = err && idx >= 32 ? 0 : longint'(refMem[idx]);
    nbits = 8 * (64'd1 << size);
    mask = (64'd1 << nbits) - 1;
    shift = (longint'(addr) % 4) * 8;
    rdata = 32'h0;
    newWord = oldWord[31:0];
    if (err) latency = 1;
    else if (!we) begin
      v = (oldWord >> shift) & mask;
      if (!uns && nbits < 32 && v >= (64'd1 << (nbits - 1))) v = v + 64'hFFFF_FFFF_0000_0000 - mask - 1 + 64'h1_0000_0000 - 64'h1_0000_0000 + (64'h1_0000_0000 - (64'd1 << nbits)) - (64'hFFFF_FFFF_0000_0000 - mask - 1);
      rdata = v[31:0];
      latency = 2;
    end else begin
      v = (oldWord & ~(mask << shift)) | ((longint'(wdata) & mask) << shift);
      newWord = v[31:0];
      latency = (size == 2'd2) ? 2 : 3;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int holdCycles,
                               output logic [31:0] rdata, output logic err, output int latency);
    @(negedge clk);
    checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = size;
    bus.req_unsigned = uns;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    acceptCycle = cycle;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    latency = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        latency = cycle - acceptCycle;
        break;
      end
    end
    if (latency == 0) checkOutput("resp_timeout", 32'(bus.resp_valid), 32'd1);
    rdata = bus.resp_rdata;
    err = bus.resp_err;
    for (int h = 0; h < holdCycles; h++) begin
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_size = 2'b10;
      bus.req_addr = 32'h0;
      bus.req_wdata = $urandom;
      @(negedge clk);
      checkOutput("hold_rdata", bus.resp_rdata, rdata);
      checkOutput("hold_err", 32'(bus.resp_err), 32'(err));
      checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic runReq(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int holdCycles,
                        output logic [31:0] rdata);
    logic expErr, err;
    logic [31:0] expRdata, newWord;
    int expLat, lat, weBefore, idx;
    modelAccess(we, size, uns, addr, wdata, expErr, expRdata, newWord, expLat);
    weBefore = weCount;
    applyStimulus(we, size, uns, addr, wdata, holdCycles, rdata, err, lat);
    checkOutput({tag, "_err"}, 32'(err), 32'(expErr));
    checkOutput({tag, "_rdata"}, rdata, expRdata);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_we_count"}, 32'(weCount - weBefore), (we && !expErr) ? 32'd1 : 32'd0);
    idx = int'(addr >> 2);
    if (we && !expErr) begin
      checkOutput({tag, "_we_offset"}, 32'(weOffset), (size == 2'd2) ? 32'd1 : 32'd2);
      checkOutput({tag, "_we_addr"}, weIdx, 32'(idx));
      checkOutput({tag, "_we_data"}, weData, newWord);
      refMem[idx] = newWord;
    end
    if (idx < 32) checkOutput({tag, "_mem"}, mem[idx], refMem[idx]);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0] sz;
    logic [31:0] ad;
    int weBefore;

    pokeEn = 1'b0;
    pokeIdx = 5'd0;
    pokeData = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 32; i++) poke(i, $urandom);

    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_dm_we", 32'(bus.dm_we), 32'd0);
    checkOutput("rst_dm_addr", bus.dm_addr, 32'h0);
    checkOutput("rst_dm_wd", bus.dm_wd, 32'h0);
    rst = 1'b0;

    poke(5, 32'h80817F80);
    runReq("lb_14", 1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 0, rd);
    checkOutput("lb_14_const", rd, 32'hFFFFFF80);
    runReq("lbu_14", 1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 0, rd);
    checkOutput("lbu_14_const", rd, 32'h00000080);
    runReq("lh_16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 0, rd);
    checkOutput("lh_16_const", rd, 32'hFFFF8081);
    runReq("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 0, rd);
    checkOutput("lhu_16_const", rd, 32'h00008081);

    poke(5, 32'h11223344);
    runReq("sb_15", 1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFFAB, 0, rd);
    checkOutput("sb_15_const", mem[5], 32'h1122AB44);

    runReq("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 0, rd);
    checkOutput("sw_20_const", mem[8], 32'hDEADBEEF);

    runReq("err_lw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, rd);
    runReq("err_sh_03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, 0, rd);
    runReq("err_size3", 1'b1, 2'b11, 1'b0, 32'h10, 32'h5555, 0, rd);
    runReq("err_lw_80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, rd);

    poke(5, 32'h80817F80);
    runReq("hold_lh_14", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 3, rd);
    checkOutput("hold_lh_14_const", rd, 32'h00007F80);
    runReq("after_hold", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0, rd);

    poke(5, 32'h11223344);
    @(negedge clk);
    checkOutput("rmw_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h15;
    bus.req_wdata = 32'h000000AB;
    acceptCycle = cycle;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rmw_write_we", 32'(bus.dm_we), 32'd1);
    weBefore = weCount;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rmw_rst_no_write", 32'(weCount - weBefore), 32'd0);
    checkOutput("rmw_rst_mem", mem[5], 32'h11223344);
    checkOutput("rmw_rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rmw_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rmw_rst_dm_we", 32'(bus.dm_we), 32'd0);
    checkOutput("rmw_rst_dm_addr", bus.dm_addr, 32'h0);
    checkOutput("rmw_rst_dm_wd", bus.dm_wd, 32'h0);
    rst = 1'b0;
    runReq("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0, rd);
    checkOutput("post_rst_lw_const", rd, 32'h11223344);

    for (int n = 0; n < 80; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 135);
      runReq("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
             $urandom_range(0, 2), rd);
    end

    for (int i = 0; i < 32; i++) checkOutput("final_mem", mem[i], refMem[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
